enemy_spawn_scheduler: RTL and testbench
========================================

Name: enemy_spawn_scheduler

Overview:
- Sequences the respawning of the four enemy tanks through one shared spawn point. Only one tank is enabled at a time.
- Applies a per-tank respawn delay after each death, a round-robin grant with a cooldown gap between spawns, and a per-wave enemy quota.
- Sits between the enemy tank state outputs and the per-tank enable inputs in the 4 Hz game logic domain.

Parameters:
- START_DLY, 3: gap ticks before the first spawn after game start.
- SPAWN_HOLD, 4: ticks tank_en stays high per grant (must be ≥1).
- GAP, 7: cooldown ticks after tank_en falls before the next grant.
- RESPAWN_DLY, 12: ticks from death detection to respawn request (must be ≥1).
- WAVE_TOTAL, 20: spawns allowed per wave (must be ≤255).

Ports:
- clk_4Hz  in  1  game tick clock. One clock only; reset is asynchronous and active-high.
- rst  in  1  asynchronous active-high reset.
- game_en  in  1  level: 1 runs the wave, 0 aborts it and returns to IDLE.
- tank_state  in  4  bit i = 1 while enemy tank i is alive.
- spawn_busy  in  1  spawn area occupied; grants are blocked while high.
- tank_en  out  4  one-hot (or zero) spawn enable for the tanks.
- grant_id  out  2  index of the last granted tank.
- remain_cnt  out  8  spawns left in the wave.
- wave_clear  out  1  high in DONE.

Behaviour:
- Reset (async, any time): state=IDLE; tank_en=0; grant_id=0; remain_cnt=0; wave_clear=0; req=0; all dly_cnt=0; gap_cnt=0; hold_cnt=0; ptr=0; tank_state_d=0.
- States: IDLE, RUN, SPAWN, DONE. game_en=0 in any non-IDLE state: next edge goes to IDLE and clears req, dly_cnt and tank_en. remain_cnt holds its value.
- IDLE, when game_en=1: next edge enters RUN with req=4'b1111, remain_cnt=WAVE_TOTAL, gap_cnt=START_DLY, ptr=0.
- RUN: gap_cnt decrements to 0 and saturates there.
- Grant condition: at an edge where gap_cnt==0, req≠0, spawn_busy==0 and remain_cnt>0, grant g = first set req bit searching from ptr upward, mod 4. On that edge:
  - tank_en[g]=1, grant_id=g, req[g]=0
  - remain_cnt decrements by 1
  - ptr=(g+1) mod 4
  - hold_cnt=SPAWN_HOLD-1, state=SPAWN
- SPAWN: hold_cnt decrements each edge. On the edge where hold_cnt==0:
  - tank_en=0, gap_cnt=GAP, return to RUN.
  - If tank_state[g]==0 at that edge, the spawn has failed; see Optional Feature.
  - tank_en is therefore high exactly SPAWN_HOLD cycles.
  - Grant rising edges are spaced SPAWN_HOLD+GAP+1 ticks apart (12 with defaults).
- Death detection, evaluated every edge in RUN and SPAWN:
  - Death of tank i = tank_state_d[i]==1 && tank_state[i]==0.
  - It is accepted only if req[i]==0, dly_cnt[i]==0 and tank_en[i]==0. Accepting it loads dly_cnt[i]=RESPAWN_DLY.
  - A nonzero dly_cnt decrements each edge. On the edge where it equals 1, req[i] is set, so req appears RESPAWN_DLY edges after the detection edge.
  - tank_state_d is registered every edge in all states.
- Simultaneous events: deaths, delay expiries and a grant on the same edge are all applied. A request set on an edge is not eligible for grant until the next edge.
- Quota exhausted: while remain_cnt==0, pending requests stay set but are never granted.
- Transition to DONE: from RUN when remain_cnt==0, tank_state==0 and gap_cnt==0. DONE drives wave_clear=1 and clears req and dly_cnt; stays until game_en=0.
- Widths: all counters are 8 bits.

Optional Feature:
- Macro: SPAWN_RETRY_EN.
- Defined: a failed spawn sets req[g]=1 immediately and increments remain_cnt by 1, refunding the quota; the retry still waits for GAP.
- Undefined: a failed spawn is treated as a death, loading dly_cnt[g]=RESPAWN_DLY; no quota refund.

Test Plan:
- Start, defaults: rst, then game_en=1, tank_state=0 (tanks report alive only while enabled) -> tank_en rises for tank0, tank1, tank2, tank3 at ticks 4, 16, 28, 40 after game_en is sampled; each is high 4 ticks; remain_cnt ends at 16.
- Death and respawn: all tanks alive, tank2 drops at tick T -> req[2] at T+12; tank_en[2] rises on the next edge once gap_cnt=0.
- Arbitration: tanks 0 and 3 request together with ptr=1 -> tank3 is granted first; tank0 is granted 12 ticks later.
- spawn_busy=1 held for 10 ticks with a request pending -> no grant during that time; grant on the first edge after it deasserts.
- Quota: WAVE_TOTAL=5, tanks killed as soon as they spawn -> exactly 5 grants; wave_clear=1 once all are dead; dropping game_en returns to IDLE.
- Failed spawn (tank_state stays 0 through the hold), plus async rst asserted mid-SPAWN:
  - With SPAWN_RETRY_EN: remain_cnt restored and the same tank re-granted after GAP+1 ticks.
  - Without SPAWN_RETRY_EN: re-granted after RESPAWN_DLY.
  - rst mid-SPAWN: tank_en=0 immediately.

Source files
------------

// File: rtl/enemy_spawn_scheduler.sv
// enemy_spawn_scheduler
//   Schedules respawns of four enemy tanks through one shared spawn point.
//   Each death triggers a respawn delay. Pending requests are granted
//   round-robin, with a cooldown gap between grants, up to a per-wave quota.
//
// Ports
//   i_clk_4Hz      game tick clock
//   i_rst          asynchronous active-high reset
//   i_game_en      1 runs the wave, 0 aborts it and returns to IDLE
//   i_tank_state   bit i = 1 while enemy tank i is alive
//   i_spawn_busy   spawn area occupied; blocks grants
//   o_tank_en      one-hot (or zero) spawn enable
//   o_grant_id     index of the last granted tank
//   o_remain_cnt   spawns left in the wave
//   o_wave_clear   high in DONE
//
// Optional feature macro: SPAWN_RETRY_EN
//   defined   : a failed spawn re-requests immediately and refunds the quota
//   undefined : a failed spawn is treated as a death (respawn delay, no refund)
//
// state | meaning
// IDLE  | waiting for game_en
// RUN   | counting down the gap, arbitrating pending requests
// SPAWN | tank_en held high for the granted tank
// DONE  | quota used up and all tanks dead; wave_clear high
module enemy_spawn_scheduler #(
    parameter int START_DLY   = 3,
    parameter int SPAWN_HOLD  = 4,
    parameter int GAP         = 7,
    parameter int RESPAWN_DLY = 12,
    parameter int WAVE_TOTAL  = 20
) (
    input  logic       i_clk_4Hz,
    input  logic       i_rst,
    input  logic       i_game_en,
    input  logic [3:0] i_tank_state,
    input  logic       i_spawn_busy,
    output logic [3:0] o_tank_en,
    output logic [1:0] o_grant_id,
    output logic [7:0] o_remain_cnt,
    output logic       o_wave_clear
);

    localparam logic [7:0] C_START = 8'(START_DLY);
    localparam logic [7:0] C_HOLD  = 8'(SPAWN_HOLD - 1);
    localparam logic [7:0] C_GAP   = 8'(GAP);
    localparam logic [7:0] C_RESP  = 8'(RESPAWN_DLY);
    localparam logic [7:0] C_WAVE  = 8'(WAVE_TOTAL);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_SPAWN, S_DONE} state_t;

    state_t      r_state, w_state_n;
    logic [3:0]  r_req, w_req_n;
    logic [7:0]  r_dly [4];
    logic [7:0]  w_dly_n [4];
    logic [7:0]  r_gap, w_gap_n;
    logic [7:0]  r_hold, w_hold_n;
    logic [1:0]  r_ptr, w_ptr_n;
    logic [3:0]  r_tank_en, w_tank_en_n;
    logic [1:0]  r_grant_id, w_grant_id_n;
    logic [7:0]  r_remain, w_remain_n;
    logic [3:0]  r_ts_d;

    logic        w_gnt_vld;
    logic [1:0]  w_gnt;
    logic        w_can_grant;

    // Round-robin search from r_ptr upward; iterating the largest offset first
    // lets the nearest set request overwrite the others.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (r_req[r_ptr + 2'(k)]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = r_ptr + 2'(k);
            end
        end
    end

    assign w_can_grant = (r_gap == 8'd0) && w_gnt_vld && !i_spawn_busy && (r_remain != 8'd0);

    always_comb begin
        w_state_n    = r_state;
        w_req_n      = r_req;
        w_dly_n      = r_dly;
        w_gap_n      = r_gap;
        w_hold_n     = r_hold;
        w_ptr_n      = r_ptr;
        w_tank_en_n  = r_tank_en;
        w_grant_id_n = r_grant_id;
        w_remain_n   = r_remain;

        // Respawn delays and death detection run in both active states.
        if (r_state == S_RUN || r_state == S_SPAWN) begin
            for (int i = 0; i < 4; i++) begin
                if (r_dly[i] != 8'd0) begin
                    w_dly_n[i] = r_dly[i] - 8'd1;
                    if (r_dly[i] == 8'd1)
                        w_req_n[i] = 1'b1;
                end
                if (r_ts_d[i] && !i_tank_state[i] && !r_req[i] &&
                    (r_dly[i] == 8'd0) && !r_tank_en[i])
                    w_dly_n[i] = C_RESP;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (i_game_en) begin
                    w_state_n  = S_RUN;
                    w_req_n    = 4'b1111;
                    w_remain_n = C_WAVE;
                    w_gap_n    = C_START;
                    w_ptr_n    = 2'd0;
                end
            end
            S_RUN: begin
                if (r_gap != 8'd0)
                    w_gap_n = r_gap - 8'd1;
                if (w_can_grant) begin
                    w_tank_en_n    = 4'b0001 << w_gnt;
                    w_grant_id_n   = w_gnt;
                    w_req_n[w_gnt] = 1'b0;
                    w_remain_n     = r_remain - 8'd1;
                    w_ptr_n        = w_gnt + 2'd1;
                    w_hold_n       = C_HOLD;
                    w_state_n      = S_SPAWN;
                end else if ((r_remain == 8'd0) && (i_tank_state == 4'b0000) && (r_gap == 8'd0)) begin
                    w_state_n = S_DONE;
                end
            end
            S_SPAWN: begin
                if (r_hold == 8'd0) begin
                    w_tank_en_n = 4'b0000;
                    w_gap_n     = C_GAP;
                    w_state_n   = S_RUN;
                    if (!i_tank_state[r_grant_id]) begin
`ifdef SPAWN_RETRY_EN
                        w_req_n[r_grant_id] = 1'b1;
                        w_remain_n          = r_remain + 8'd1;
`else
                        w_dly_n[r_grant_id] = C_RESP;
`endif
                    end
                end else begin
                    w_hold_n = r_hold - 8'd1;
                end
            end
            S_DONE: begin
                w_req_n = 4'b0000;
                w_dly_n = '{default: 8'd0};
            end
            default: w_state_n = S_IDLE;
        endcase

        // Abort overrides everything else; remain_cnt is kept for inspection.
        if (r_state != S_IDLE && !i_game_en) begin
            w_state_n   = S_IDLE;
            w_req_n     = 4'b0000;
            w_dly_n     = '{default: 8'd0};
            w_tank_en_n = 4'b0000;
        end
    end

    always_ff @(posedge i_clk_4Hz or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_req      <= 4'b0000;
            r_dly      <= '{default: 8'd0};
            r_gap      <= 8'd0;
            r_hold     <= 8'd0;
            r_ptr      <= 2'd0;
            r_tank_en  <= 4'b0000;
            r_grant_id <= 2'd0;
            r_remain   <= 8'd0;
            r_ts_d     <= 4'b0000;
        end else begin
            r_state    <= w_state_n;
            r_req      <= w_req_n;
            r_dly      <= w_dly_n;
            r_gap      <= w_gap_n;
            r_hold     <= w_hold_n;
            r_ptr      <= w_ptr_n;
            r_tank_en  <= w_tank_en_n;
            r_grant_id <= w_grant_id_n;
            r_remain   <= w_remain_n;
            r_ts_d     <= i_tank_state;
        end
    end

    assign o_tank_en    = r_tank_en;
    assign o_grant_id   = r_grant_id;
    assign o_remain_cnt = r_remain;
    assign o_wave_clear = (r_state == S_DONE);

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Testbench for enemy_spawn_scheduler: table-driven start-up sequence plus
// hand-written sequences for respawn, arbitration, busy blocking, quota,
// failed spawns and asynchronous reset. A second instance uses WAVE_TOTAL=5.
module tb_enemy_spawn_scheduler;

    logic       clk;
    logic       rst;
    logic       game_en, busy;
    logic [3:0] ts;
    logic [3:0] te;
    logic [1:0] gid;
    logic [7:0] rem;
    logic       wc;
    logic       game_en_q, busy_q;
    logic [3:0] ts_q;
    logic [3:0] te_q;
    logic [1:0] gid_q;
    logic [7:0] rem_q;
    logic       wc_q;

    int n_checks = 0;
    int n_fail   = 0;
    bit follow   = 0;
    bit follow_q = 0;

    enemy_spawn_scheduler u_dut (
        .i_clk_4Hz(clk), .i_rst(rst), .i_game_en(game_en), .i_tank_state(ts),
        .i_spawn_busy(busy), .o_tank_en(te), .o_grant_id(gid),
        .o_remain_cnt(rem), .o_wave_clear(wc)
    );

    enemy_spawn_scheduler #(.WAVE_TOTAL(5)) u_quota (
        .i_clk_4Hz(clk), .i_rst(rst), .i_game_en(game_en_q), .i_tank_state(ts_q),
        .i_spawn_busy(busy_q), .o_tank_en(te_q), .o_grant_id(gid_q),
        .o_remain_cnt(rem_q), .o_wave_clear(wc_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         adv;
        logic       game_en;
        logic       busy;
        logic [3:0] te;
        logic [1:0] gid;
        logic [7:0] rem;
        logic       wc;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Tanks in follow mode report alive exactly while they are enabled.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (follow)   ts   = te;
            if (follow_q) ts_q = te_q;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        game_en = 1'b0; busy = 1'b0; ts = 4'b0000;
        game_en_q = 1'b0; busy_q = 1'b0; ts_q = 4'b0000;
        follow = 0; follow_q = 0;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int grants;
        logic [3:0] prev;

        //           adv  gen   busy  te       gid   rem     wc
        vecs[0]  = '{1,  1'b1, 1'b0, 4'b0000, 2'd0, 8'd20, 1'b0};
        vecs[1]  = '{3,  1'b1, 1'b0, 4'b0000, 2'd0, 8'd20, 1'b0};
        vecs[2]  = '{1,  1'b1, 1'b0, 4'b0001, 2'd0, 8'd19, 1'b0};
        vecs[3]  = '{3,  1'b1, 1'b0, 4'b0001, 2'd0, 8'd19, 1'b0};
        vecs[4]  = '{1,  1'b1, 1'b0, 4'b0000, 2'd0, 8'd19, 1'b0};
        vecs[5]  = '{8,  1'b1, 1'b0, 4'b0010, 2'd1, 8'd18, 1'b0};
        vecs[6]  = '{4,  1'b1, 1'b0, 4'b0000, 2'd1, 8'd18, 1'b0};
        vecs[7]  = '{8,  1'b1, 1'b0, 4'b0100, 2'd2, 8'd17, 1'b0};
        vecs[8]  = '{11, 1'b1, 1'b0, 4'b0000, 2'd2, 8'd17, 1'b0};
        vecs[9]  = '{1,  1'b1, 1'b0, 4'b1000, 2'd3, 8'd16, 1'b0};
        vecs[10] = '{3,  1'b1, 1'b0, 4'b1000, 2'd3, 8'd16, 1'b0};
        vecs[11] = '{1,  1'b1, 1'b0, 4'b0000, 2'd3, 8'd16, 1'b0};
        vecs[12] = '{8,  1'b1, 1'b0, 4'b0001, 2'd0, 8'd15, 1'b0};

        // Reset state
        do_reset();
        chk("reset_te", 8'(te), 8'h0);
        chk("reset_gid", 8'(gid), 8'h0);
        chk("reset_rem", rem, 8'h0);
        chk("reset_wc", 8'(wc), 8'h0);

        // Start-up sequence, tanks alive only while enabled
        follow = 1;
        for (int v = 0; v < 13; v++) begin
            game_en = vecs[v].game_en;
            busy    = vecs[v].busy;
            tick(vecs[v].adv);
            chk($sformatf("vec%0d_te", v),  8'(te),  8'(vecs[v].te));
            chk($sformatf("vec%0d_gid", v), 8'(gid), 8'(vecs[v].gid));
            chk($sformatf("vec%0d_rem", v), rem,     vecs[v].rem);
            chk($sformatf("vec%0d_wc", v),  8'(wc),  8'(vecs[v].wc));
        end

        // Death and respawn of tank2, then spawn_busy blocking tank1
        do_reset();
        ts = 4'b1111; game_en = 1'b1;
        tick(1);
        tick(52);
        ts = 4'b1011;
        tick(12);
        chk("respawn_e64_te", 8'(te), 8'h0);
        tick(1);
        chk("respawn_e65_te", 8'(te), 8'h0);
        tick(1);
        chk("respawn_e66_te", 8'(te), 8'h4);
        chk("respawn_e66_gid", 8'(gid), 8'd2);
        chk("respawn_e66_rem", rem, 8'd15);
        ts = 4'b1111;
        tick(11);
        ts = 4'b1101;
        tick(8);
        busy = 1'b1;
        tick(6);
        chk("busy_e91_te", 8'(te), 8'h0);
        tick(4);
        chk("busy_e95_te", 8'(te), 8'h0);
        busy = 1'b0;
        tick(1);
        chk("busy_e96_te", 8'(te), 8'h2);
        chk("busy_e96_gid", 8'(gid), 8'd1);
        chk("busy_e96_rem", rem, 8'd14);

        // Arbitration: tanks 0 and 3 request together with ptr=1
        do_reset();
        ts = 4'b1111; game_en = 1'b1;
        tick(1);
        tick(8);
        ts = 4'b1110;
        tick(44);
        chk("arb_e52_te", 8'(te), 8'h1);
        chk("arb_e52_rem", rem, 8'd15);
        ts = 4'b1111;
        tick(4);
        ts = 4'b0110;
        tick(13);
        chk("arb_e69_te", 8'(te), 8'h0);
        tick(1);
        chk("arb_e70_te", 8'(te), 8'h8);
        chk("arb_e70_gid", 8'(gid), 8'd3);
        chk("arb_e70_rem", rem, 8'd14);
        ts = 4'b1110;
        tick(12);
        chk("arb_e82_te", 8'(te), 8'h1);
        chk("arb_e82_gid", 8'(gid), 8'd0);
        chk("arb_e82_rem", rem, 8'd13);

        // Quota of 5 with tanks dying as soon as their enable drops
        do_reset();
        game_en = 1'b0;
        follow_q = 1; game_en_q = 1'b1;
        grants = 0; prev = 4'b0000;
        for (int c = 0; c <= 63; c++) begin
            tick(1);
            if ((te_q & ~prev) != 4'b0000) grants++;
            prev = te_q;
        end
        chk("quota_e63_wc", 8'(wc_q), 8'h0);
        chk("quota_e63_rem", rem_q, 8'd0);
        tick(1);
        chk("quota_e64_wc", 8'(wc_q), 8'h1);
        for (int c = 0; c < 30; c++) begin
            tick(1);
            if ((te_q & ~prev) != 4'b0000) grants++;
            prev = te_q;
        end
        chk("quota_grants", 8'(grants), 8'd5);
        chk("quota_done_wc", 8'(wc_q), 8'h1);
        game_en_q = 1'b0;
        tick(1);
        chk("quota_idle_wc", 8'(wc_q), 8'h0);
        chk("quota_idle_rem", rem_q, 8'd0);
        game_en_q = 1'b1;
        tick(1);
        chk("quota_restart_rem", rem_q, 8'd5);
        game_en_q = 1'b0; follow_q = 0;

        // Failed spawn of tank0
        do_reset();
        ts = 4'b1111; game_en = 1'b1;
        tick(1);
        tick(51);
        ts = 4'b1110;
        tick(14);
        chk("fail_e65_te", 8'(te), 8'h1);
        chk("fail_e65_rem", rem, 8'd15);
        tick(4);
        chk("fail_e69_te", 8'(te), 8'h0);
`ifdef SPAWN_RETRY_EN
        chk("fail_e69_rem", rem, 8'd16);
        tick(8);
        chk("fail_e77_te", 8'(te), 8'h1);
        chk("fail_e77_rem", rem, 8'd15);
        tick(5);
        chk("fail_e82_te", 8'(te), 8'h0);
        chk("fail_e82_rem", rem, 8'd16);
`else
        chk("fail_e69_rem", rem, 8'd15);
        tick(8);
        chk("fail_e77_te", 8'(te), 8'h0);
        chk("fail_e77_rem", rem, 8'd15);
        tick(5);
        chk("fail_e82_te", 8'(te), 8'h1);
        chk("fail_e82_rem", rem, 8'd14);
`endif

        // Asynchronous reset in the middle of SPAWN
        do_reset();
        ts = 4'b1111; game_en = 1'b1;
        tick(1);
        tick(5);
        chk("arst_pre_te", 8'(te), 8'h1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_te", 8'(te), 8'h0);
        chk("arst_gid", 8'(gid), 8'h0);
        chk("arst_rem", rem, 8'h0);
        rst = 1'b0;
        game_en = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
